// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and default width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 64;

  // 2'd3 is never entered; the FSM decodes it as IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_controller_full_adder.sv
// Single-bit full adder; the only arithmetic element of the serial adder.
module FullAdder1Bit (
  input  logic Ci,
  input  logic A,
  input  logic B,
  output logic S,
  output logic Co
);

  assign S  = A ^ B ^ Ci;
  assign Co = (A & B) | (Ci & (A ^ B));

endmodule

// File: rtl/serial_adder_controller.sv
// Bit-serial WIDTH-bit adder: one FullAdder1Bit sequenced LSB first, one bit per clock,
// with a start/ready/done handshake and abort.
module serial_adder_controller
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Abort,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic             Ready,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             Ov
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] ra, rb, rs, rs_nxt;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             s_fa, co_fa;
  logic             last, accept, step;

  FullAdder1Bit u_fa (
    .Ci (c),
    .A  (ra[0]),
    .B  (rb[0]),
    .S  (s_fa),
    .Co (co_fa)
  );

  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = Ready & Start;
  assign step   = Busy & ~Abort;
  assign rs_nxt = {s_fa, rs[WIDTH-1:1]};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = ST_IDLE;
    Ready     = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      ST_RUN: begin
        Busy = 1'b1;
        if (Abort)     state_nxt = ST_IDLE;
        else if (last) state_nxt = ST_DONE;
        else           state_nxt = ST_RUN;
      end
      ST_DONE: begin
        Done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        Ready     = 1'b1;
        state_nxt = Start ? ST_RUN : ST_IDLE;
      end
    endcase
  end

  // Commit on the final bit edge so S/Co/Ov are already valid while Done is high.
  // The carry into the MSB is c at that edge, so Ov = carry-out ^ c.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ra  <= '0;
      rb  <= '0;
      rs  <= '0;
      c   <= 1'b0;
      cnt <= '0;
      S   <= '0;
      Co  <= 1'b0;
      Ov  <= 1'b0;
    end else if (accept) begin
      ra  <= A;
      rb  <= B;
      c   <= Ci;
      cnt <= '0;
    end else if (step) begin
      ra <= ra >> 1;
      rb <= rb >> 1;
      rs <= rs_nxt;
      c  <= co_fa;
      if (last) begin
        S  <= rs_nxt;
        Co <= co_fa;
        Ov <= co_fa ^ c;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_controller.sv
// Scoreboard bench for serial_adder_controller: stimulus pushes expected results,
// a Done-triggered monitor pops and compares sum, carry, overflow and latency.
module tb_serial_adder_controller;

  localparam int W = 64;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           acc;
  } exp_t;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         Start = 1'b0;
  logic         Abort = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Ci = 1'b0;
  logic         Ready, Busy, Done, Co, Ov;
  logic [W-1:0] S;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  serial_adder_controller #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort),
    .A(A), .B(B), .Ci(Ci),
    .Ready(Ready), .Busy(Busy), .Done(Done), .S(S), .Co(Co), .Ov(Ov)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (!Reset && Done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sum", S, e.s);
        chk("carry", W'(Co), W'(e.co));
        chk("overflow", W'(Ov), W'(e.ov));
        chk("latency", W'(cyc - e.acc), W'(W + 1));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!Ready && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (!Ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 expected=1");
    end
  endtask

  // Drive one request at a negedge where Ready is high; optionally push its expectation.
  task automatic start_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                           input bit push, input logic [W-1:0] es, input logic eco, input logic eov);
    exp_t e;
    wait_ready();
    A = a; B = b; Ci = ci; Start = 1'b1;
    if (push) begin
      e.s = es; e.co = eco; e.ov = eov; e.acc = cyc;
      q.push_back(e);
    end
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!Done && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (!Done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=0 expected=1");
    end
  endtask

  initial begin
    logic [W:0]   ref_sum;
    logic [W-1:0] ra, rb;
    logic         rci, rov;

    repeat (3) @(negedge Clk);
    chk("reset_s", S, '0);
    chk("reset_flags", W'({Co, Ov, Done, Busy, Ready}), W'(5'b00001));
    Reset = 1'b0;
    @(negedge Clk);

    // 1: minimal add, latency and Ready return
    start_add(64'd1, 64'd0, 1'b0, 1, 64'd1, 1'b0, 1'b0);
    chk("busy_in_run", W'({Busy, Ready}), W'(2'b10));
    wait_done();
    @(negedge Clk);
    chk("ready_after_done", W'({Ready, Done}), W'(2'b10));

    // 2: carry-out and signed overflow corners
    start_add(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1, 64'd0, 1'b1, 1'b0);
    start_add(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1, 64'h8000_0000_0000_0000, 1'b0, 1'b1);

    // 3: Start while busy and in DONE is ignored
    start_add(64'd5, 64'd3, 1'b1, 1, 64'd9, 1'b0, 1'b0);
    repeat (10) @(negedge Clk);
    chk("ready_low_run", W'(Ready), W'(0));
    A = 64'd77; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    wait_done();
    chk("ready_low_done", W'(Ready), W'(0));
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (70) @(negedge Clk);
    chk("idle_after_ignored", W'({Busy, Ready}), W'(2'b01));

    // 4: abort leaves committed outputs intact
    start_add(64'd2, 64'd2, 1'b0, 1, 64'd4, 1'b0, 1'b0);
    start_add(64'd100, 64'd23, 1'b0, 0, '0, 1'b0, 1'b0);
    repeat (20) @(negedge Clk);
    Abort = 1'b1;
    @(negedge Clk);
    Abort = 1'b0;
    chk("abort_ready", W'({Ready, Busy, Done}), W'(3'b100));
    chk("abort_s_hold", S, 64'd4);
    chk("abort_co_hold", W'(Co), W'(0));
    repeat (70) @(negedge Clk);
    start_add(64'd100, 64'd23, 1'b0, 1, 64'd123, 1'b0, 1'b0);

    // 5: asynchronous reset mid-add
    start_add(64'd1000, 64'd1, 1'b0, 0, '0, 1'b0, 1'b0);
    repeat (30) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("async_reset_s", S, '0);
    chk("async_reset_flags", W'({Busy, Ready, Done}), W'(3'b010));
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    start_add(64'd1000, 64'd1, 1'b0, 1, 64'd1001, 1'b0, 1'b0);

    // 6: back-to-back random regression against a reference sum
    for (int i = 0; i < 1000; i++) begin
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      rci = 1'($urandom_range(0, 1));
      ref_sum = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rci};
      rov = (ra[W-1] == rb[W-1]) && (ref_sum[W-1] != ra[W-1]);
      start_add(ra, rb, rci, 1, ref_sum[W-1:0], ref_sum[W], rov);
    end
    wait_ready();
    @(negedge Clk);
    chk("scoreboard_drained", W'(q.size()), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
